sseg_scan_decoder: RTL and testbench
====================================

// Module: sseg_scan_decoder
// PURPOSE
//  Passive receiver for a multiplexed, active-low seven-segment bus (per-digit anode + {dp,g..a}).
//  Samples each digit while its anode dwells and inverse-decodes the segment pattern to a hex nibble + dp.
//  Publishes a full N-digit frame only after STABLE_FRAMES identical consecutive scans.
//  Used on-board for display self-check and as a bench/ILA monitor of the display driver.
// PARAMETERS
//  N_DIGITS       4  number of multiplexed digits (anode width)
//  SETTLE         2  cycles an (anode,segment) pair must be unchanged before capture, >=1
//  STABLE_FRAMES  2  identical consecutive frames required before publish, >=1
// PORTS
//  i_clk       in   1           system clock
//  i_rst       in   1           synchronous reset, active-high
//  i_an_n      in   N_DIGITS    anodes, active-low; bit k low selects digit k
//  i_sseg_n    in   8           {dp_n, g,f,e,d,c,b,a}, active-low
//  o_hex       out  4*N_DIGITS  published nibbles; digit k at [4k+3:4k]
//  o_dp        out  N_DIGITS    published decimal points, active-high
//  o_bad       out  N_DIGITS    published flag: digit k pattern not a hex glyph
//  o_valid     out  1           1-cycle pulse when a frame is published
//  o_collide   out  1           1-cycle pulse when >1 anode observed low
// BEHAVIOUR
//  - Reset: one-cycle synchronous; all outputs 0, slots/seen/counters cleared, FSM->IDLE. Reset mid-dwell or mid-frame discards partial data.
//  - Inputs registered once (1-cycle latency); all decisions use registered an/sseg.
//  - Anode qualify: exactly one bit low -> active index k; all high -> idle; >1 low -> o_collide pulse, dwell aborted (->IDLE).
//  - Dwell FSM: IDLE -> SETTLE on valid one-hot anode; SETTLE counts cycles with an/sseg unchanged;
//    any change restarts count (new anode/pattern re-enters SETTLE); count==SETTLE -> capture, ->HOLD;
//    HOLD ignores further cycles until anode or sseg changes (one capture per dwell); all-high -> IDLE.
//  - Decode (7 bits, g..a): 40->0 79->1 24->2 30->3 19->4 12->5 02->6 78->7 00->8 10->9
//    08->A 03->B 46->C 21->D 06->E 0E->F (hex of the 7-bit active-low pattern); any other (incl. blank 7F) -> nibble 0, bad=1.
//  - dp = ~dp_n. Capture writes slot k {hex,dp,bad}, sets seen[k]; recapture of a seen slot overwrites it.
//  - Frame complete when seen==all ones: compare slots to previous frame; equal -> match_cnt+1 (saturate), else match_cnt=1;
//    store frame as previous; clear seen. Completion cycle is the cycle after the last capture.
//  - Publish when match_cnt reaches STABLE_FRAMES: o_hex/o_dp/o_bad update and o_valid pulses the same cycle; then match_cnt holds at STABLE_FRAMES
//    so each further identical frame republishes.
//  - Simultaneous capture of last digit and new anode change: capture wins, new dwell starts next cycle.
// CONFIGURATION
//  SSEG_DEC_PUBLISH_ON_CHANGE_EN defined: o_valid (and output update) only when qualified frame differs from currently published value;
//    first qualified frame after reset always publishes.
//  Undefined: every qualified frame pulses o_valid, including repeats.
// TESTING (N_DIGITS=4, SETTLE=2, STABLE_FRAMES=2, 8-cycle dwells, macro undefined unless stated)
//  1. Scan digits 0..3 with 1,2,3,4 (79,24,30,19), dp off, 2 scans -> o_hex=16'h4321, o_dp=0, o_bad=0, one o_valid after scan 2.
//  2. Digit 2 driven 7F, others as 1 -> o_bad=4'b0100, o_hex[11:8]=0, dp_n=0 on digit 0 -> o_dp=4'b0001.
//  3. Each anode dwells 1 cycle only -> no capture, o_valid never asserts.
//  4. i_an_n=4'b1100 for 3 cycles mid-scan -> one o_collide pulse, no slot written.
//  5. Scans 4321,4325,4325 -> no publish after 2nd scan, o_valid after 3rd with o_hex=16'h4325.
//  6. i_rst mid-frame -> all outputs 0 next cycle; 2 clean scans needed to publish; with SSEG_DEC_PUBLISH_ON_CHANGE_EN,
//     4 identical scans -> exactly one o_valid.

Source files
------------

// File: rtl/sseg_scan_decoder.sv
// Passive monitor of a multiplexed active-low 7-segment bus; rebuilds the displayed hex frame. Optional macro: SSEG_DEC_PUBLISH_ON_CHANGE_EN.
// Latency: 1 input register + SETTLE dwell cycles + frame completion; no backpressure, the bus is observed only.
module sseg_scan_decoder #(
    parameter int N_DIGITS      = 4,
    parameter int SETTLE        = 2,
    parameter int STABLE_FRAMES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [N_DIGITS-1:0]   i_an_n,
    input  logic [7:0]            i_sseg_n,
    output logic [4*N_DIGITS-1:0] o_hex,
    output logic [N_DIGITS-1:0]   o_dp,
    output logic [N_DIGITS-1:0]   o_bad,
    output logic                  o_valid,
    output logic                  o_collide
);

    localparam int IW  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int NLW = $clog2(N_DIGITS + 1);
    localparam int CW  = $clog2(SETTLE + 1);
    localparam int MW  = $clog2(STABLE_FRAMES + 1);
    localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);
    localparam logic [MW-1:0] STABLE_C = MW'(STABLE_FRAMES);

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_HOLD} state_t;
    state_t state, state_nx;

    logic [N_DIGITS-1:0]   an_q, lat_an;
    logic [7:0]            sseg_q, lat_sseg;
    logic [CW-1:0]         cnt, cnt_nx;
    logic                  coll_q;
    logic [4*N_DIGITS-1:0] slot_hex, prev_hex;
    logic [N_DIGITS-1:0]   slot_dp, slot_bad, prev_dp, prev_bad, seen;
    logic [MW-1:0]         match_cnt, match_nx;
    logic [NLW-1:0]        n_low;
    logic [IW-1:0]         idx;
    logic [4:0]            dec;
    logic                  one_hot, coll, latch, capture, complete, frame_eq, publish;
`ifdef SSEG_DEC_PUBLISH_ON_CHANGE_EN
    logic                  published;
`endif

    // Result is {bad, nibble}; unknown glyphs (including blank) report nibble 0 with bad set.
    function automatic logic [4:0] glyph_decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h40: r = 5'h00;
            7'h79: r = 5'h01;
            7'h24: r = 5'h02;
            7'h30: r = 5'h03;
            7'h19: r = 5'h04;
            7'h12: r = 5'h05;
            7'h02: r = 5'h06;
            7'h78: r = 5'h07;
            7'h00: r = 5'h08;
            7'h10: r = 5'h09;
            7'h08: r = 5'h0A;
            7'h03: r = 5'h0B;
            7'h46: r = 5'h0C;
            7'h21: r = 5'h0D;
            7'h06: r = 5'h0E;
            7'h0E: r = 5'h0F;
            default: r = 5'h10;
        endcase
        return r;
    endfunction

    always_comb begin
        n_low = '0;
        idx   = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (!an_q[k]) begin
                n_low = n_low + 1'b1;
                idx   = IW'(k);
            end
        end
        one_hot = (n_low == NLW'(1));
        coll    = (n_low > NLW'(1));
    end

    assign dec = glyph_decode(sseg_q[6:0]);

    // Any change of anode or pattern restarts the settle count; HOLD blocks repeat captures.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        latch    = 1'b0;
        capture  = 1'b0;
        if (!one_hot) begin
            state_nx = ST_IDLE;
        end else if (state == ST_IDLE || an_q != lat_an || sseg_q != lat_sseg) begin
            latch  = 1'b1;
            cnt_nx = CW'(1);
            if (cnt_nx == SETTLE_C) begin
                capture  = 1'b1;
                state_nx = ST_HOLD;
            end else begin
                state_nx = ST_SETTLE;
            end
        end else if (state == ST_SETTLE) begin
            cnt_nx = cnt + 1'b1;
            if (cnt_nx == SETTLE_C) begin
                capture  = 1'b1;
                state_nx = ST_HOLD;
            end
        end
    end

    assign complete = &seen;
    assign frame_eq = ({slot_hex, slot_dp, slot_bad} == {prev_hex, prev_dp, prev_bad});

    always_comb begin
        match_nx = match_cnt;
        publish  = 1'b0;
        if (complete) begin
            if (!frame_eq)
                match_nx = MW'(1);
            else if (match_cnt != STABLE_C)
                match_nx = match_cnt + 1'b1;
            publish = (match_nx == STABLE_C);
`ifdef SSEG_DEC_PUBLISH_ON_CHANGE_EN
            if (published && ({slot_hex, slot_dp, slot_bad} == {o_hex, o_dp, o_bad}))
                publish = 1'b0;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            an_q      <= '1;
            sseg_q    <= '1;
            lat_an    <= '1;
            lat_sseg  <= '1;
            state     <= ST_IDLE;
            cnt       <= '0;
            coll_q    <= 1'b0;
            slot_hex  <= '0;
            slot_dp   <= '0;
            slot_bad  <= '0;
            seen      <= '0;
            prev_hex  <= '0;
            prev_dp   <= '0;
            prev_bad  <= '0;
            match_cnt <= '0;
            o_hex     <= '0;
            o_dp      <= '0;
            o_bad     <= '0;
            o_valid   <= 1'b0;
            o_collide <= 1'b0;
`ifdef SSEG_DEC_PUBLISH_ON_CHANGE_EN
            published <= 1'b0;
`endif
        end else begin
            an_q      <= i_an_n;
            sseg_q    <= i_sseg_n;
            state     <= state_nx;
            cnt       <= cnt_nx;
            coll_q    <= coll;
            o_collide <= coll & ~coll_q;
            if (latch) begin
                lat_an   <= an_q;
                lat_sseg <= sseg_q;
            end
            if (capture) begin
                slot_hex[{idx, 2'b00} +: 4] <= dec[3:0];
                slot_dp[idx]                <= ~sseg_q[7];
                slot_bad[idx]               <= dec[4];
            end
            // A capture landing on the completion cycle belongs to the next frame.
            seen <= (complete ? '0 : seen) | (capture ? ~an_q : '0);
            if (complete) begin
                prev_hex  <= slot_hex;
                prev_dp   <= slot_dp;
                prev_bad  <= slot_bad;
                match_cnt <= match_nx;
            end
            o_valid <= publish;
            if (publish) begin
                o_hex <= slot_hex;
                o_dp  <= slot_dp;
                o_bad <= slot_bad;
`ifdef SSEG_DEC_PUBLISH_ON_CHANGE_EN
                published <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Bench for sseg_scan_decoder: constant frame table, dwell/collision/reset sequences, random frames against a frame-level model.
module tb_sseg_scan_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  an_n;
    logic [7:0]  sseg_n;
    logic [15:0] o_hex;
    logic [3:0]  o_dp, o_bad;
    logic        o_valid, o_collide;

    always #5 clk = ~clk;

    sseg_scan_decoder #(.N_DIGITS(4), .SETTLE(2), .STABLE_FRAMES(2)) dut (
        .i_clk(clk), .i_rst(rst), .i_an_n(an_n), .i_sseg_n(sseg_n),
        .o_hex(o_hex), .o_dp(o_dp), .o_bad(o_bad), .o_valid(o_valid), .o_collide(o_collide)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int vcnt     = 0;
    int ccnt     = 0;

    always @(negedge clk) begin
        if (o_valid === 1'b1)   vcnt++;
        if (o_collide === 1'b1) ccnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Frame-level reference: glyph lookup plus the stable-frame publishing rule.
    logic [6:0]  glyph [16];
    logic [23:0] m_prev, m_pub;
    int          m_cnt;
    bit          m_have, m_pub_once;

    function automatic logic [23:0] ref_frame(input logic [31:0] fr);
        logic [15:0] hx;
        logic [3:0]  dp, bd;
        logic [7:0]  s;
        hx = '0; dp = '0; bd = '1;
        for (int k = 0; k < 4; k++) begin
            s     = fr[8*k +: 8];
            dp[k] = ~s[7];
            for (int g = 0; g < 16; g++) begin
                if (s[6:0] == glyph[g]) begin
                    hx[4*k +: 4] = 4'(g);
                    bd[k]        = 1'b0;
                end
            end
        end
        return {bd, dp, hx};
    endfunction

    task automatic model_reset();
        m_prev = '0; m_pub = '0; m_cnt = 0; m_have = 0; m_pub_once = 0;
    endtask

    task automatic model_scan(input logic [23:0] f, output int ev);
        bit pub;
        if (m_have && f == m_prev) m_cnt = (m_cnt < 2) ? m_cnt + 1 : 2;
        else                       m_cnt = 1;
        m_prev = f;
        m_have = 1;
        pub = (m_cnt == 2);
`ifdef SSEG_DEC_PUBLISH_ON_CHANGE_EN
        if (m_pub_once && f == m_pub) pub = 0;
`endif
        ev = 0;
        if (pub) begin
            m_pub = f;
            m_pub_once = 1;
            ev = 1;
        end
    endtask

    task automatic drive_digit(input int k, input logic [7:0] s, input int dwell);
        logic [3:0] m;
        m = 4'b0001 << k;
        @(negedge clk);
        an_n   = ~m;
        sseg_n = s;
        repeat (dwell - 1) @(negedge clk);
    endtask

    task automatic do_scan(input logic [31:0] fr, input int coll_at);
        for (int k = 0; k < 4; k++) begin
            drive_digit(k, fr[8*k +: 8], 8);
            if (k == coll_at) begin
                @(negedge clk);
                an_n = 4'b1100;
                repeat (2) @(negedge clk);
            end
        end
        @(negedge clk);
        an_n   = 4'hF;
        sseg_n = 8'hFF;
        repeat (4) @(negedge clk);
    endtask

    task automatic model_check(input string tag, input logic [31:0] fr, input int coll_at);
        int v0, c0, ev;
        v0 = vcnt;
        c0 = ccnt;
        do_scan(fr, coll_at);
        model_scan(ref_frame(fr), ev);
        chk({tag, " valid"}, 32'(vcnt - v0), 32'(ev));
        chk({tag, " collide"}, 32'(ccnt - c0), (coll_at >= 0) ? 32'd1 : 32'd0);
        chk({tag, " hex"}, {16'h0, o_hex}, {16'h0, m_pub[15:0]});
        chk({tag, " dp"}, {28'h0, o_dp}, {28'h0, m_pub[19:16]});
        chk({tag, " bad"}, {28'h0, o_bad}, {28'h0, m_pub[23:20]});
    endtask

    typedef struct {
        logic [31:0] fr;
        int          ev;
        int          ev_chg;
        logic [15:0] hex;
        logic [3:0]  dp;
        logic [3:0]  bad;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int v0, c0, ev;
        logic [31:0] fr, last_fr;

        glyph[0]  = 7'h40; glyph[1]  = 7'h79; glyph[2]  = 7'h24; glyph[3]  = 7'h30;
        glyph[4]  = 7'h19; glyph[5]  = 7'h12; glyph[6]  = 7'h02; glyph[7]  = 7'h78;
        glyph[8]  = 7'h00; glyph[9]  = 7'h10; glyph[10] = 7'h08; glyph[11] = 7'h03;
        glyph[12] = 7'h46; glyph[13] = 7'h21; glyph[14] = 7'h06; glyph[15] = 7'h0E;

        tbl[0] = '{32'h99B0A4F9, 0, 0, 16'h0000, 4'h0, 4'h0};
        tbl[1] = '{32'h99B0A4F9, 1, 1, 16'h4321, 4'h0, 4'h0};
        tbl[2] = '{32'h99B0A492, 0, 0, 16'h4321, 4'h0, 4'h0};
        tbl[3] = '{32'h99B0A492, 1, 1, 16'h4325, 4'h0, 4'h0};
        tbl[4] = '{32'h99B0A492, 1, 0, 16'h4325, 4'h0, 4'h0};
        tbl[5] = '{32'hF9FFF979, 0, 0, 16'h4325, 4'h0, 4'h0};
        tbl[6] = '{32'hF9FFF979, 1, 1, 16'h1011, 4'h1, 4'h4};
        tbl[7] = '{32'h8E86C080, 0, 0, 16'h1011, 4'h1, 4'h4};
        tbl[8] = '{32'h8E86C080, 1, 1, 16'hFE08, 4'h0, 4'h0};

        rst = 1'b1; an_n = 4'hF; sseg_n = 8'hFF;
        repeat (3) @(negedge clk);
        chk("reset hex", {16'h0, o_hex}, 32'h0);
        chk("reset dp", {28'h0, o_dp}, 32'h0);
        chk("reset bad", {28'h0, o_bad}, 32'h0);
        chk("reset valid", {31'h0, o_valid}, 32'h0);
        chk("reset collide", {31'h0, o_collide}, 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
`ifdef SSEG_DEC_PUBLISH_ON_CHANGE_EN
            ev = tbl[i].ev_chg;
`else
            ev = tbl[i].ev;
`endif
            v0 = vcnt;
            do_scan(tbl[i].fr, -1);
            chk($sformatf("tbl%0d valid", i), 32'(vcnt - v0), 32'(ev));
            chk($sformatf("tbl%0d hex", i), {16'h0, o_hex}, {16'h0, tbl[i].hex});
            chk($sformatf("tbl%0d dp", i), {28'h0, o_dp}, {28'h0, tbl[i].dp});
            chk($sformatf("tbl%0d bad", i), {28'h0, o_bad}, {28'h0, tbl[i].bad});
        end

        // One-cycle dwells must never capture; the following FE08 scan then still matches the stored frame.
        v0 = vcnt;
        for (int r = 0; r < 10; r++)
            for (int k = 0; k < 4; k++)
                drive_digit(k, tbl[0].fr[8*k +: 8], 1);
        @(negedge clk);
        an_n = 4'hF; sseg_n = 8'hFF;
        repeat (4) @(negedge clk);
        chk("short dwell valid", 32'(vcnt - v0), 32'd0);
        v0 = vcnt;
        do_scan(32'h8E86C080, -1);
`ifdef SSEG_DEC_PUBLISH_ON_CHANGE_EN
        chk("after short dwell valid", 32'(vcnt - v0), 32'd0);
`else
        chk("after short dwell valid", 32'(vcnt - v0), 32'd1);
`endif
        chk("after short dwell hex", {16'h0, o_hex}, 32'h0000FE08);

        // Collision for 3 cycles mid-scan: exactly one pulse, frame unaffected.
        v0 = vcnt; c0 = ccnt;
        do_scan(32'h8E86C080, 1);
        chk("collide pulses", 32'(ccnt - c0), 32'd1);
`ifdef SSEG_DEC_PUBLISH_ON_CHANGE_EN
        chk("collide scan valid", 32'(vcnt - v0), 32'd0);
`else
        chk("collide scan valid", 32'(vcnt - v0), 32'd1);
`endif

        // Reset partway through a frame.
        drive_digit(0, 8'hF9, 8);
        drive_digit(1, 8'hA4, 8);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset hex", {16'h0, o_hex}, 32'h0);
        chk("midreset dp", {28'h0, o_dp}, 32'h0);
        chk("midreset bad", {28'h0, o_bad}, 32'h0);
        chk("midreset valid", {31'h0, o_valid}, 32'h0);
        rst = 1'b0;
        model_reset();
        v0 = vcnt;
        for (int i = 0; i < 4; i++)
            model_check($sformatf("post-reset scan%0d", i), 32'h99B0A492, -1);
`ifdef SSEG_DEC_PUBLISH_ON_CHANGE_EN
        chk("post-reset total valid", 32'(vcnt - v0), 32'd1);
`else
        chk("post-reset total valid", 32'(vcnt - v0), 32'd3);
`endif

        last_fr = 32'h99B0A492;
        for (int i = 0; i < 30; i++) begin
            int ca;
            if ($urandom_range(0, 2) != 0) begin
                fr = last_fr;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    logic [6:0] code;
                    if ($urandom_range(0, 3) == 0) code = 7'($urandom_range(0, 127));
                    else                           code = glyph[$urandom_range(0, 15)];
                    fr[8*k +: 8] = {1'($urandom_range(0, 1)), code};
                end
            end
            ca = int'($urandom_range(0, 7));
            if (ca > 2) ca = -1;
            model_check($sformatf("rand%0d", i), fr, ca);
            last_fr = fr;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
